// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
// Launches one frame per grant and times the frame and gap locally so that tx_data stays stable.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 10416,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CLKS     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_transmit,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
  localparam int CNT_W      = $clog2(FRAME_CLKS + GAP_CLKS + 1);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(FRAME_CLKS + GAP_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_r;
  logic [2:0]         rr_ptr_r;
  logic [CNT_W-1:0]   counter_r;

  logic               grant_vld_s;
  logic               hi_found_s;
  logic [2:0]         hi_grant_s;
  logic [2:0]         lo_grant_s;
  logic [2:0]         grant_s;
  logic [2:0]         next_ptr_s;
  logic [N_REQ-1:0]   ack_mask_s;
  logic [7:0]         sel_data_s;

  // Rotating priority: lowest set request at or above rr_ptr, else lowest set request overall.
  always_comb begin
    grant_vld_s = |req;
    hi_found_s  = 1'b0;
    hi_grant_s  = 3'd0;
    lo_grant_s  = 3'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_grant_s = 3'(k);
        if (3'(k) >= rr_ptr_r) begin
          hi_grant_s = 3'(k);
          hi_found_s = 1'b1;
        end else begin
          hi_grant_s = hi_grant_s;
        end
      end else begin
        lo_grant_s = lo_grant_s;
      end
    end
    if (hi_found_s) begin
      grant_s = hi_grant_s;
    end else begin
      grant_s = lo_grant_s;
    end
  end

  // Derived values for the granted requester: next pointer, ack one-hot and its byte.
  always_comb begin
    if (grant_s == 3'(N_REQ - 1)) begin
      next_ptr_s = 3'd0;
    end else begin
      next_ptr_s = grant_s + 3'd1;
    end
    ack_mask_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_s;
    sel_data_s = 8'd0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_s == 3'(k)) begin
        sel_data_s = req_data[8*k +: 8];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Arbiter FSM with frame/gap timer; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 3'd0;
      counter_r   <= {CNT_W{1'b0}};
      ack         <= {N_REQ{1'b0}};
      tx_transmit <= 1'b0;
      tx_data     <= 8'd0;
      busy        <= 1'b0;
      grant_id    <= 3'd0;
    end else begin
      ack         <= {N_REQ{1'b0}};
      tx_transmit <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            tx_data     <= sel_data_s;
            tx_transmit <= 1'b1;
            ack         <= ack_mask_s;
            grant_id    <= grant_s;
            rr_ptr_r    <= next_ptr_s;
            busy        <= 1'b1;
            counter_r   <= {CNT_W{1'b0}};
            state_r     <= SEND;
          end else begin
            busy        <= 1'b0;
          end
        end
        SEND: begin
          if (counter_r == FRAME_END) begin
            if (GAP_CLKS > 0) begin
              // The counter keeps running through the gap so one timer covers both phases.
              counter_r <= counter_r + CNT_ONE;
              state_r   <= GAP;
            end else begin
              counter_r <= {CNT_W{1'b0}};
              busy      <= 1'b0;
              state_r   <= IDLE;
            end
          end else begin
            counter_r <= counter_r + CNT_ONE;
          end
        end
        GAP: begin
          if (counter_r == GAP_END) begin
            counter_r <= {CNT_W{1'b0}};
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            counter_r <= counter_r + CNT_ONE;
          end
        end
        default: begin
          counter_r <= {CNT_W{1'b0}};
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N_REQ=4, CLKS_PER_BIT=4, FRAME_BITS=10, GAP_CLKS=2.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_transmit;
  logic [7:0]  tx_data;
  logic        busy;
  logic [2:0]  grant_id;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .N_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_CLKS(2)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_transmit(tx_transmit), .tx_data(tx_data), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_launch(input int limit);
    int waited;
    @(negedge clk);
    waited = 1;
    while (!tx_transmit && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check("launch_seen", {31'd0, tx_transmit}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("return_idle", {31'd0, busy}, 32'd0);
  endtask

  int          busy_cnt;
  int          hold_bad;
  int          pulses;
  int          ack1_cnt;
  int          t;
  int          last_t;
  int          n_pulse;
  logic [2:0]  exp_g [5];
  logic [7:0]  exp_d [5];

  initial begin
    exp_g = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    // Reset state
    reset = 1'b1; req = 4'b0000; req_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_tx_transmit", {31'd0, tx_transmit}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant_id", {29'd0, grant_id}, 32'd0);

    // Single request, one-clock latency, busy length and data hold
    reset = 1'b0; req = 4'b0001; req_data = 32'h000000A5;
    @(negedge clk);
    check("single_ack", {28'd0, ack}, 32'h1);
    check("single_tx_transmit", {31'd0, tx_transmit}, 32'd1);
    check("single_tx_data", {24'd0, tx_data}, 32'hA5);
    check("single_grant", {29'd0, grant_id}, 32'd0);
    req = 4'b0000;
    busy_cnt = 1; hold_bad = 0; pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && tx_data !== 8'hA5) hold_bad++;
      if (tx_transmit || ack != 4'b0000) pulses++;
    end
    check("single_busy_len", busy_cnt, 32'd42);
    check("single_hold", hold_bad, 32'd0);
    check("single_extra_pulses", pulses, 32'd0);
    check("single_busy_end", {31'd0, busy}, 32'd0);

    // All request: grants 0,1,2,3,0 spaced 43 clks
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 4'b1111; req_data = 32'h44332211;
    last_t = 0; n_pulse = 0;
    for (t = 0; t < 300 && n_pulse < 5; t++) begin
      @(negedge clk);
      if (tx_transmit) begin
        check("all_grant", {29'd0, grant_id}, {29'd0, exp_g[n_pulse]});
        check("all_data", {24'd0, tx_data}, {24'd0, exp_d[n_pulse]});
        check("all_ack", {28'd0, ack}, 32'd1 << exp_g[n_pulse]);
        if (n_pulse > 0) check("all_spacing", t - last_t, 32'd43);
        last_t = t;
        n_pulse++;
      end
    end
    req = 4'b0000;
    check("all_pulse_count", n_pulse, 32'd5);
    wait_idle();

    // Rotation: rr_ptr=1 -> grant 2, then req=0101 wraps to 0, then 2
    req = 4'b0100;
    wait_launch(10);
    check("rot_grant_a", {29'd0, grant_id}, 32'd2);
    check("rot_data_a", {24'd0, tx_data}, 32'h33);
    req = 4'b0101;
    wait_launch(60);
    check("rot_grant_b", {29'd0, grant_id}, 32'd0);
    check("rot_data_b", {24'd0, tx_data}, 32'h11);
    wait_launch(60);
    check("rot_grant_c", {29'd0, grant_id}, 32'd2);
    check("rot_ack_c", {28'd0, ack}, 32'h4);
    req = 4'b0000;
    wait_idle();

    // Withdrawal: req[1] pulses for one clk during SEND
    req = 4'b0001;
    wait_launch(10);
    check("wd_grant", {29'd0, grant_id}, 32'd0);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    ack1_cnt = 0; pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack[1]) ack1_cnt++;
      if (tx_transmit) pulses++;
    end
    check("wd_ack1", ack1_cnt, 32'd0);
    check("wd_frames", pulses, 32'd0);
    check("wd_busy_end", {31'd0, busy}, 32'd0);

    // Reset mid-frame, asynchronous to clk
    req = 4'b0100;
    wait_launch(10);
    check("mid_grant", {29'd0, grant_id}, 32'd2);
    req = 4'b0000;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ack", {28'd0, ack}, 32'd0);
    check("mid_rst_tx_transmit", {31'd0, tx_transmit}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_grant", {29'd0, grant_id}, 32'd0);
    @(negedge clk);
    reset = 1'b0; req = 4'b0010; req_data = 32'h44335A11;
    @(negedge clk);
    check("post_rst_ack", {28'd0, ack}, 32'h2);
    check("post_rst_tx_transmit", {31'd0, tx_transmit}, 32'd1);
    check("post_rst_grant", {29'd0, grant_id}, 32'd1);
    check("post_rst_data", {24'd0, tx_data}, 32'h5A);
    req = 4'b0000;

    // Data hold while req_data churns every clk
    for (int i = 0; i < 45; i++) begin
      req_data = $urandom;
      @(negedge clk);
      check("hold_tx_data", {24'd0, tx_data}, 32'h5A);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
